ecc_secded_pipe: RTL and testbench

Parametrised, pipelined Hamming SEC-DED decoder for the datapath protection layer. It replaces the fixed 32-bit single-error corrector with these capabilities:
- configurable data width
- double-error detection
- valid/ready streaming with backpressure
- a two-stage register pipeline
- optional saturating error statistics

It sits between storage or link receive logic and downstream consumers.

---
 rtl/ecc_pkg.sv | 69 ++++++
 rtl/ecc_sat_counter.sv | 23 ++
 rtl/ecc_secded_pipe.sv | 141 ++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SEC-DED helpers (check-width sizing, codeword layout, encoder)
// and the syndrome classification type used by the decoder pipeline.
package ecc_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CHK_W  = 8;

  typedef enum logic [2:0] {
    CLEAN,
    CORR_PAR,
    CORR_CHK,
    CORR_DATA,
    UNC
  } syn_class_e;

  // Hamming check bits (smallest k with 2^k >= data_w+k+1) plus the overall parity bit.
  function automatic int calc_chk_w(input int data_w);
    int res;
    res = 0;
    for (int k = 12; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) res = k + 1;
    end
    return res;
  endfunction

  // Data bit idx lives at the (idx+1)-th codeword position that is not a power of two.
  function automatic int data_pos(input int idx);
    int res;
    int cnt;
    res = 0;
    cnt = 0;
    for (int p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  // Returns the full check field: bits 0..chk_w-2 are Hamming bits, bit chk_w-1 overall parity.
  function automatic logic [MAX_CHK_W-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                  input int data_w);
    logic [MAX_CHK_W-1:0] chk;
    logic                 par;
    int                   pos;
    int                   chk_w;
    chk   = '0;
    par   = 1'b0;
    chk_w = calc_chk_w(data_w);
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        pos = data_pos(i);
        par ^= data[i];
        for (int j = 0; j < MAX_CHK_W - 1; j++) begin
          if (j < chk_w - 1 && pos[j]) chk[j] ^= data[i];
        end
      end
    end
    for (int j = 0; j < MAX_CHK_W - 1; j++) begin
      if (j < chk_w - 1) par ^= chk[j];
    end
    for (int j = 0; j < MAX_CHK_W; j++) begin
      if (j == chk_w - 1) chk[j] = par;
    end
    return chk;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// ecc_sat_counter: event counter that sticks at its maximum value; clr wins over inc.
module ecc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    res = (v == '1) ? v : v + CNT_W'(1);
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage elastic Hamming SEC-DED decoder with valid/ready flow control.
// Define ECC_STATS_EN to build the saturating corrected/uncorrectable word counters.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int CHK_W  = calc_chk_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              in_check_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_unc,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_corr_cnt,
  output logic [CNT_W-1:0]  stat_unc_cnt
);

  localparam int SYN_W    = CHK_W - 1;
  localparam int LAST_POS = data_pos(DATA_W - 1);
  localparam logic [SYN_W-1:0] SYN_ONE = SYN_W'(1);

  function automatic syn_class_e classify(input logic [SYN_W-1:0] s, input logic p);
    syn_class_e res;
    if (!p)                           res = (s == '0) ? CLEAN : UNC;
    else if (s == '0)                 res = CORR_PAR;
    else if ((s & (s - SYN_ONE)) == '0) res = CORR_CHK;
    else if (int'(s) <= LAST_POS)     res = CORR_DATA;
    else                              res = UNC;
    return res;
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [SYN_W-1:0]  syn_p1;
  logic              par_p1;
  logic              en_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic              corr_p2;
  logic              unc_p2;

  logic                 s2_accept;
  logic [MAX_CHK_W-1:0] enc_full;
  logic [SYN_W-1:0]     syn;
  logic                 par;
  logic                 unused_enc;

  assign s2_accept = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || s2_accept;

  // ---- stage 1: syndrome and overall parity of the received word ----
  assign enc_full   = encode(MAX_DATA_W'(in_data), DATA_W);
  assign syn        = enc_full[SYN_W-1:0] ^ in_chk[SYN_W-1:0];
  assign par        = (^in_data) ^ (^in_chk);
  assign unused_enc = ^enc_full;

  always_ff @(posedge clk) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_p1 <= in_data;
      syn_p1  <= syn;
      par_p1  <= par;
      en_p1   <= in_check_en;
    end
  end

  // ---- stage 2: classify, correct the flagged data bit, hold under stall ----
  syn_class_e        cls;
  logic [DATA_W-1:0] flip;
  logic [DATA_W-1:0] data_fix;

  for (genvar g = 0; g < DATA_W; g++) begin : g_flip
    localparam int POS = data_pos(g);
    assign flip[g] = (int'(syn_p1) == POS);
  end

  assign cls      = en_p1 ? classify(syn_p1, par_p1) : CLEAN;
  assign data_fix = (cls == CORR_DATA) ? (data_p1 ^ flip) : data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      corr_p2 <= 1'b0;
      unc_p2  <= 1'b0;
    end else if (s2_accept) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= data_fix;
        corr_p2 <= (cls == CORR_PAR) || (cls == CORR_CHK) || (cls == CORR_DATA);
        unc_p2  <= (cls == UNC);
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_corr  = corr_p2;
  assign out_unc   = unc_p2;

`ifdef ECC_STATS_EN
  logic fire;
  assign fire = vld_p2 && out_ready;

  ecc_sat_counter #(.CNT_W(CNT_W)) u_corr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (fire && corr_p2),
    .cnt (stat_corr_cnt)
  );

  ecc_sat_counter #(.CNT_W(CNT_W)) u_unc_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stat_clr),
    .inc (fire && unc_p2),
    .cnt (stat_unc_cnt)
  );
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_corr_cnt   = '0;
  assign stat_unc_cnt    = '0;
`endif

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb_ecc_secded_pipe: directed-vector bench for the SEC-DED decoder (DATA_W=32, CNT_W=2).
module tb_ecc_secded_pipe;

  localparam int DW = 32;
  localparam int CW = 7;
  localparam int NW = 2;
`ifdef ECC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_chk;
  logic          in_check_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_corr;
  logic          out_unc;
  logic          stat_clr;
  logic [NW-1:0] stat_corr_cnt;
  logic [NW-1:0] stat_unc_cnt;

  ecc_secded_pipe #(.DATA_W(DW), .CNT_W(NW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_chk        (in_chk),
    .in_check_en   (in_check_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_corr      (out_corr),
    .out_unc       (out_unc),
    .stat_clr      (stat_clr),
    .stat_corr_cnt (stat_corr_cnt),
    .stat_unc_cnt  (stat_unc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int corr_m = 0;
  int unc_m  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  task automatic model_fire(input bit c, input bit u, input bit clr);
    if (clr) begin
      corr_m = 0;
      unc_m  = 0;
    end else begin
      if (c) corr_m = sat3(corr_m);
      if (u) unc_m  = sat3(unc_m);
    end
  endtask

  task automatic check_cnts(input string tag);
    check_eq({tag, "_ccnt"}, 64'(stat_corr_cnt), STATS ? corr_m : 0);
    check_eq({tag, "_ucnt"}, 64'(stat_unc_cnt),  STATS ? unc_m  : 0);
  endtask

  // One word through an otherwise idle pipe with out_ready held high.
  task automatic run_vec(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit en, input logic [DW-1:0] ed, input bit ec, input bit eu,
                         input bit clr);
    int lat;
    bit fired;
    in_data     = d;
    in_chk      = c;
    in_check_en = en;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd2);
    check_eq({tag, "_data"}, 64'(out_data), 64'(ed));
    check_eq({tag, "_flags"}, {62'd0, out_corr, out_unc}, {62'd0, ec, eu});
    fired    = out_valid;
    stat_clr = clr;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    if (fired) model_fire(ec, eu, clr);
    check_cnts(tag);
  endtask

  logic [DW-1:0] bp_d  [8] = '{32'h1111_0000, 32'h1, 32'h2222_0002, 32'h8000_0001,
                               32'h4444_0004, 32'h3, 32'h6666_0006, 32'h0};
  logic [CW-1:0] bp_c  [8] = '{7'h00, 7'h43, 7'h00, 7'h43, 7'h00, 7'h00, 7'h00, 7'h26};
  bit            bp_en [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [DW-1:0] bp_ed [8] = '{32'h1111_0000, 32'h1, 32'h2222_0002, 32'h1,
                               32'h4444_0004, 32'h3, 32'h6666_0006, 32'h8000_0000};
  bit            bp_ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  bit            bp_eu [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int            sent;
    int            rcv;
    bit            acc;
    bit            prev_stall;
    bit            seen;
    logic [DW-1:0] last_d;
    logic [1:0]    last_f;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk = '0; in_check_en = 1'b1;
    out_ready = 1'b1; stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_flags", {62'd0, out_corr, out_unc}, 64'd0);
    check_cnts("rst");

    run_vec("clean",     32'h0,          7'h00, 1'b1, 32'h0,          1'b0, 1'b0, 1'b0);
    run_vec("data_err",  32'h1,          7'h00, 1'b1, 32'h0,          1'b1, 1'b0, 1'b0);
    run_vec("chk0_err",  32'h0,          7'h01, 1'b1, 32'h0,          1'b1, 1'b0, 1'b0);
    run_vec("par_err",   32'h0,          7'h40, 1'b1, 32'h0,          1'b1, 1'b0, 1'b0);
    run_vec("dbl_err",   32'h3,          7'h00, 1'b1, 32'h3,          1'b0, 1'b1, 1'b0);
    run_vec("bypass",    32'h3,          7'h00, 1'b0, 32'h3,          1'b0, 1'b0, 1'b0);
    run_vec("cw_clean",  32'h1,          7'h43, 1'b1, 32'h1,          1'b0, 1'b0, 1'b0);
    run_vec("msb_err",   32'h8000_0001,  7'h43, 1'b1, 32'h1,          1'b1, 1'b0, 1'b0);
    run_vec("syn_max",   32'h0,          7'h7F, 1'b1, 32'h0,          1'b0, 1'b1, 1'b0);
    run_vec("chk5_err",  32'h0,          7'h20, 1'b1, 32'h0,          1'b1, 1'b0, 1'b0);
    run_vec("syn_past",  32'h0,          7'h67, 1'b1, 32'h0,          1'b0, 1'b1, 1'b0);
    run_vec("syn_last",  32'h0,          7'h26, 1'b1, 32'h8000_0000,  1'b1, 1'b0, 1'b0);

    // Plain clear with no handshake, then saturation from five corrections.
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    model_fire(1'b0, 1'b0, 1'b1);
    check_cnts("clr_idle");
    for (int i = 0; i < 5; i++)
      run_vec("sat", 32'h1, 7'h00, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    run_vec("clr_fire", 32'h1, 7'h00, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream with out_ready high one cycle in three.
    sent = 0; rcv = 0; prev_stall = 1'b0; last_d = '0; last_f = '0;
    for (int cyc = 0; cyc < 80 && rcv < 8; cyc++) begin
      out_ready = (cyc % 3 == 2);
      if (sent < 8) begin
        in_valid    = 1'b1;
        in_data     = bp_d[sent];
        in_chk      = bp_c[sent];
        in_check_en = bp_en[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (prev_stall) begin
        check_eq("bp_hold_vld", 64'(out_valid), 64'd1);
        check_eq("bp_hold_data", 64'(out_data), 64'(last_d));
        check_eq("bp_hold_flags", {62'd0, out_corr, out_unc}, {62'd0, last_f});
      end
      prev_stall = out_valid && !out_ready;
      last_d     = out_data;
      last_f     = {out_corr, out_unc};
      if (out_valid && out_ready) begin
        check_eq("bp_data", 64'(out_data), 64'(bp_ed[rcv]));
        check_eq("bp_flags", {62'd0, out_corr, out_unc}, {62'd0, bp_ec[rcv], bp_eu[rcv]});
        model_fire(bp_ec[rcv], bp_eu[rcv], 1'b0);
        rcv++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check_eq("bp_sent", 64'(sent), 64'd8);
    check_eq("bp_rcv", 64'(rcv), 64'd8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_drained", 64'(out_valid), 64'd0);
    check_cnts("bp");

    // Fill the stalled pipe, then reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_chk = 7'h43; in_check_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("mid_pre_vld", 64'(out_valid), 64'd1);
    check_eq("mid_pre_rdy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_vld", 64'(out_valid), 64'd0);
    check_eq("mid_rst_data", 64'(out_data), 64'd0);
    check_eq("mid_rst_rdy", 64'(in_ready), 64'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    model_fire(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check_eq("mid_no_output", 64'(seen), 64'd0);
    check_cnts("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
